spi_register_transceiver: RTL

- SPI slave front end for the register interface between the Raspberry Pi and the register/control logic.
- Consumes the already-synchronized sck/sdi/cs signals. Parses each transaction into an 8-bit command byte followed by one or more 32-bit data words.
- Shifts back the read word that the register logic supplies after each command.
- Sits directly downstream of spi_synchronizer and directly upstream of the register-decode logic that drives the sampler core.

---
 rtl/spi_register_transceiver_if.sv | 27 ++
 rtl/spi_register_transceiver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_register_transceiver_if.sv
// Bus between the SPI transceiver and its neighbours: synchronized SPI pins
// on one side, command/word handshake to the register-decode logic on the other.
interface spi_register_transceiver_if #(
    parameter int COMMAND_WIDTH = 8,
    parameter int WORD_WIDTH    = 32
);
    logic [WORD_WIDTH-1:0]    word_to_output;
    logic [WORD_WIDTH-1:0]    word_received;
    logic [COMMAND_WIDTH-1:0] command;
    logic                     command_ready;
    logic                     word_rx_complete;
    logic                     sck;
    logic                     sdi;
    logic                     cs;
    logic                     sdo;
    logic                     frame_error;

    modport slave (
        input  word_to_output, sck, sdi, cs,
        output word_received, command, command_ready, word_rx_complete, sdo, frame_error
    );

    modport master (
        output word_to_output, sck, sdi, cs,
        input  word_received, command, command_ready, word_rx_complete, sdo, frame_error
    );
endinterface

// File: rtl/spi_register_transceiver.sv
// SPI mode-0 slave: 8-bit command byte then a burst of 32-bit words each way.
// Optional sticky truncated-frame detection is built when SPI_FRAME_ERROR_EN is defined.
module spi_register_transceiver #(
    parameter int COMMAND_WIDTH = 8,
    parameter int WORD_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    spi_register_transceiver_if.slave     bus
);
    localparam int CNT_W = $clog2((WORD_WIDTH > COMMAND_WIDTH) ? WORD_WIDTH : COMMAND_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(COMMAND_WIDTH - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_COMMAND, S_DATA} state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_sck_prev;
    logic                     r_cs_prev;
    logic [CNT_W-1:0]         r_cnt;
    // Shift registers hold only the bits before the final one; the last bit
    // is taken straight from sdi when the byte/word completes.
    logic [COMMAND_WIDTH-2:0] r_cmd_shift;
    logic [WORD_WIDTH-2:0]    r_rx_shift;
    logic [WORD_WIDTH-1:0]    r_tx_shift;
    logic                     r_tx_loaded;
    logic [COMMAND_WIDTH-1:0] r_command;
    logic [WORD_WIDTH-1:0]    r_word_received;
    logic                     r_command_ready;
    logic                     r_word_rx_complete;

    logic w_rise;
    logic w_fall;
    logic w_cs_fall;
    logic w_cnt_clear;
    logic w_abort;
    logic w_cmd_shift_en;
    logic w_cmd_done;
    logic w_rx_shift_en;
    logic w_word_done;
    logic w_tx_load;
    logic w_tx_shift;

    assign w_rise    = bus.sck & ~r_sck_prev & ~bus.cs;
    assign w_fall    = ~bus.sck & r_sck_prev & ~bus.cs;
    // r_cs_prev resets low so a cs held low across reset never looks like a new frame.
    assign w_cs_fall = r_cs_prev & ~bus.cs;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        w_cnt_clear    = 1'b0;
        w_abort        = 1'b0;
        w_cmd_shift_en = 1'b0;
        w_cmd_done     = 1'b0;
        w_rx_shift_en  = 1'b0;
        w_word_done    = 1'b0;
        w_tx_load      = 1'b0;
        w_tx_shift     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_next_state = S_COMMAND;
                    w_cnt_clear  = 1'b1;
                end
            end
            S_COMMAND: begin
                if (bus.cs) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else if (w_rise) begin
                    w_cmd_shift_en = 1'b1;
                    if (r_cnt == CMD_LAST) begin
                        w_cmd_done   = 1'b1;
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.cs) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    if (w_fall) begin
                        w_tx_load  = ~r_tx_loaded;
                        w_tx_shift = r_tx_loaded;
                    end
                    if (w_rise) begin
                        w_rx_shift_en = 1'b1;
                        w_word_done   = (r_cnt == WORD_LAST);
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sck_prev         <= 1'b0;
            r_cs_prev          <= 1'b0;
            r_cnt              <= '0;
            r_cmd_shift        <= '0;
            r_rx_shift         <= '0;
            r_tx_shift         <= '0;
            r_tx_loaded        <= 1'b0;
            r_command          <= '0;
            r_word_received    <= '0;
            r_command_ready    <= 1'b0;
            r_word_rx_complete <= 1'b0;
        end else begin
            r_sck_prev         <= bus.sck;
            r_cs_prev          <= bus.cs;
            r_command_ready    <= w_cmd_done;
            r_word_rx_complete <= w_word_done;

            if (w_cnt_clear || w_abort || w_cmd_done || w_word_done)
                r_cnt <= '0;
            else if (w_cmd_shift_en || w_rx_shift_en)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_cnt_clear || w_abort)
                r_cmd_shift <= '0;
            else if (w_cmd_shift_en)
                r_cmd_shift <= {r_cmd_shift[COMMAND_WIDTH-3:0], bus.sdi};
            if (w_cmd_done)
                r_command <= {r_cmd_shift, bus.sdi};

            if (w_cnt_clear || w_abort)
                r_rx_shift <= '0;
            else if (w_rx_shift_en)
                r_rx_shift <= {r_rx_shift[WORD_WIDTH-3:0], bus.sdi};
            if (w_word_done)
                r_word_received <= {r_rx_shift, bus.sdi};

            // sdo is the tx MSB; clearing the register outside DATA keeps sdo low there.
            if (w_next_state != S_DATA) begin
                r_tx_shift  <= '0;
                r_tx_loaded <= 1'b0;
            end else begin
                if (w_tx_load) begin
                    r_tx_shift  <= bus.word_to_output;
                    r_tx_loaded <= 1'b1;
                end else if (w_tx_shift) begin
                    r_tx_shift <= {r_tx_shift[WORD_WIDTH-2:0], 1'b0};
                end
                if (w_word_done)
                    r_tx_loaded <= 1'b0;
            end
        end
    end

`ifdef SPI_FRAME_ERROR_EN
    logic r_frame_error;

    // Any cs rise mid-command (even with zero bits) or mid-word is a truncated frame.
    always_ff @(posedge clk) begin
        if (reset)
            r_frame_error <= 1'b0;
        else if (w_abort && ((r_state == S_COMMAND) || (r_cnt != '0)))
            r_frame_error <= 1'b1;
    end

    assign bus.frame_error = r_frame_error;
`else
    assign bus.frame_error = 1'b0;
`endif

    assign bus.word_received    = r_word_received;
    assign bus.command          = r_command;
    assign bus.command_ready    = r_command_ready;
    assign bus.word_rx_complete = r_word_rx_complete;
    assign bus.sdo              = r_tx_shift[WORD_WIDTH-1];
endmodule
